cassette_status_overlay: RTL

//  Pixel-stream stage directly downstream of the 640x400 VGA timing/pixel generator.

---
 rtl/cassette_status_overlay.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/cassette_status_overlay.sv
// Cassette status overlay: draws a bordered status box with a tape progress bar and a
// blinking PLAY lamp on top of the VGA pixel stream. Two register stages; every output
// is the input two pclk earlier, mixed.
module cassette_status_overlay #(
    parameter int unsigned BOX_X        = 16,
    parameter int unsigned BOX_Y        = 360,
    parameter int unsigned BOX_W        = 288,
    parameter int unsigned BOX_H        = 32,
    parameter int unsigned BLINK_FRAMES = 30
) (
    input  logic       pclk,
    input  logic       reset,
    input  logic       ovl_en,
    input  logic [7:0] progress,
    input  logic       playing,
    input  logic [9:0] hcount,
    input  logic [9:0] vcount,
    input  logic [7:0] r_in,
    input  logic [7:0] g_in,
    input  logic [7:0] b_in,
    input  logic       hs_in,
    input  logic       vs_in,
    input  logic       hb_in,
    input  logic       vb_in,
    input  logic       de_in,
    output logic [7:0] r,
    output logic [7:0] g,
    output logic [7:0] b,
    output logic       hs,
    output logic       vs,
    output logic       hb,
    output logic       vb,
    output logic       de
);

    localparam int unsigned FcntW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    // Frame-latched control state
    logic             vb_prev;
    logic             en_s;
    logic [7:0]       progress_s;
    logic             playing_s;
    logic [FcntW-1:0] fcnt;
    logic             blink;
    logic             vb_rise;

    assign vb_rise = vb_in & ~vb_prev;

    // Shadow registers and blink counter update only on the vblank rising edge
    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            vb_prev    <= 1'b0;
            en_s       <= 1'b0;
            progress_s <= 8'd0;
            playing_s  <= 1'b0;
            fcnt       <= '0;
            blink      <= 1'b0;
        end else begin
            vb_prev <= vb_in;
            if (vb_rise) begin
                en_s       <= ovl_en;
                progress_s <= progress;
                playing_s  <= playing;
                if (fcnt == FcntW'(BLINK_FRAMES - 1)) begin
                    fcnt  <= '0;
                    blink <= ~blink;
                end else begin
                    fcnt <= fcnt + FcntW'(1);
                end
            end
        end
    end

    // Stage-1 geometry, 11-bit so BOX_X+BOX_W cannot wrap
    logic [10:0] h11, v11, rx, ry;
    logic [7:0]  bx;
    logic        inbox_c, border_c, row_c, bar_c, lamp_c, fill_c;

    // Box-relative coordinates and region flags for the incoming pixel
    always_comb begin
        h11      = {1'b0, hcount};
        v11      = {1'b0, vcount};
        rx       = h11 - 11'(BOX_X);
        ry       = v11 - 11'(BOX_Y);
        inbox_c  = (h11 >= 11'(BOX_X)) && (h11 < 11'(BOX_X + BOX_W)) &&
                   (v11 >= 11'(BOX_Y)) && (v11 < 11'(BOX_Y + BOX_H));
        border_c = inbox_c && ((rx == 11'd0) || (rx == 11'(BOX_W - 1)) ||
                               (ry == 11'd0) || (ry == 11'(BOX_H - 1)));
        row_c    = (ry >= 11'd12) && (ry < 11'd20);
        bar_c    = inbox_c && row_c && (rx >= 11'd16) && (rx < 11'd272);
        lamp_c   = inbox_c && row_c && (rx >= 11'd276) && (rx < 11'd284);
        // Low byte suffices: rx-16 lies in 0..255 whenever bar_c is set
        bx       = rx[7:0] - 8'd16;
        fill_c   = bar_c && (bx < progress_s);
    end

    // Stage-1 registers
    logic [7:0] r1, g1, b1;
    logic       hs1, vs1, hb1, vb1, de1;
    logic       inbox1, border1, bar1, lamp1, fill1, en1, red1;

    // Delay the source stream alongside the geometry flags and a control snapshot
    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            r1      <= 8'd0;
            g1      <= 8'd0;
            b1      <= 8'd0;
            hs1     <= 1'b0;
            vs1     <= 1'b0;
            hb1     <= 1'b0;
            vb1     <= 1'b0;
            de1     <= 1'b0;
            inbox1  <= 1'b0;
            border1 <= 1'b0;
            bar1    <= 1'b0;
            lamp1   <= 1'b0;
            fill1   <= 1'b0;
            en1     <= 1'b0;
            red1    <= 1'b0;
        end else begin
            r1      <= r_in;
            g1      <= g_in;
            b1      <= b_in;
            hs1     <= hs_in;
            vs1     <= vs_in;
            hb1     <= hb_in;
            vb1     <= vb_in;
            de1     <= de_in;
            inbox1  <= inbox_c;
            border1 <= border_c;
            bar1    <= bar_c;
            lamp1   <= lamp_c;
            fill1   <= fill_c;
            en1     <= en_s;
            red1    <= playing_s & blink;
        end
    end

    logic [23:0] mix;

    // Stage-2 colour priority select
    always_comb begin
        mix = {r1, g1, b1};
        if (!de1) begin
            mix = 24'h000000;
        end else if (!en1 || !inbox1) begin
            mix = {r1, g1, b1};
        end else if (border1) begin
            mix = 24'hFFFFFF;
        end else if (lamp1 && red1) begin
            mix = 24'hFF0000;
        end else if (fill1) begin
            mix = 24'h00FF00;
        end else if (bar1) begin
            mix = 24'h202020;
        end else begin
            mix = {1'b0, r1[7:1], 1'b0, g1[7:1], 1'b0, b1[7:1]};
        end
    end

    // Output registers
    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            r  <= 8'd0;
            g  <= 8'd0;
            b  <= 8'd0;
            hs <= 1'b1;
            vs <= 1'b0;
            hb <= 1'b1;
            vb <= 1'b1;
            de <= 1'b0;
        end else begin
            {r, g, b} <= mix;
            hs <= hs1;
            vs <= vs1;
            hb <= hb1;
            vb <= vb1;
            de <= de1;
        end
    end

endmodule
